// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared FSM states and stack op encoding for stack_arbiter
package stack_arb_pkg;
  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, CAPT, RESP} state_t;
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP = 1'b1;
endpackage

// File: rtl/stack_arbiter_rr.sv
// rr_arb2: two-requester round-robin arbiter; on a tie the requester not served last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       idx
);
  always_comb begin
    idx = (req == 2'b11) ? ~last : req[1];
    grant = (req == 2'b00) ? 2'b00 : (idx ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: serializes two requesters onto a single hardware stack port,
// tracking occupancy so overflow/underflow are rejected before reaching the stack
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             flush,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic [DEPTH:0]   count,
  output logic             stk_en,
  output logic             stk_ctrl,
  output logic [WIDTH-1:0] stk_din,
  output logic             stk_clr_n,
  input  logic [WIDTH-1:0] stk_dout
);
  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
  state_t state, state_n;
  logic win, op_l, err_l, rr_last, flush_pend, legal, fire, a_idx;
  logic [1:0] a_gnt;
  logic [WIDTH-1:0] data_l;
  rr_arb2 u_arb (
    .req  (req),
    .last (rr_last),
    .grant(a_gnt),
    .idx  (a_idx)
  );
  always_comb begin
    legal = (op_l == OP_PUSH) ? (count != CAP) : (count != '0);
    fire = (state == ISSUE) && legal;
    state_n = (state == FLUSH) ? IDLE :
              (state == IDLE)  ? ((flush || flush_pend) ? FLUSH : (|a_gnt ? ISSUE : IDLE)) :
              (state == ISSUE) ? ((fire && op_l == OP_POP) ? CAPT : RESP) :
              (state == CAPT)  ? RESP : IDLE;
    gnt = (state == ISSUE) ? (win ? 2'b10 : 2'b01) : 2'b00;
    done = (state == RESP) ? (win ? 2'b10 : 2'b01) : 2'b00;
    err = (state == RESP) && err_l;
    stk_en = fire;
    stk_ctrl = fire && op_l;
    stk_din = fire ? data_l : '0;
    stk_clr_n = (state != FLUSH);
  end
  // a flush outside IDLE is remembered and served once the current transaction ends
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= FLUSH;
      count <= '0;
      rdata <= '0;
      rr_last <= 1'b1;
      win <= 1'b0;
      op_l <= 1'b0;
      data_l <= '0;
      err_l <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_n;
      flush_pend <= (state == IDLE) ? 1'b0 : (flush_pend || flush);
      if (state == IDLE) begin
        win <= a_idx;
        op_l <= op[a_idx];
        data_l <= a_idx ? wdata1 : wdata0;
      end
      if (state == ISSUE) begin
        rr_last <= win;
        err_l <= !legal;
        if (legal) count <= (op_l == OP_POP) ? count - 1'b1 : count + 1'b1;
      end
      if (state == FLUSH) count <= '0;
      if (state == CAPT) rdata <= stk_dout;
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed self-checking bench with a behavioral 4-entry stack
module tb_stack_arbiter;
  logic clk = 0, clr = 1, flush = 0;
  logic [1:0] req = 0, op = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic [1:0] gnt, done;
  logic err, stk_en, stk_ctrl, stk_clr_n;
  logic [7:0] rdata, stk_din, stk_dout;
  logic [2:0] count;
  logic [7:0] mem [4];
  logic [2:0] sp;
  int n_cmp = 0, n_bad = 0;

  stack_arbiter #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .wdata0(wdata0), .wdata1(wdata1),
    .flush(flush), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .count(count),
    .stk_en(stk_en), .stk_ctrl(stk_ctrl), .stk_din(stk_din), .stk_clr_n(stk_clr_n),
    .stk_dout(stk_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!stk_clr_n) begin
      sp <= 0;
      stk_dout <= 0;
    end else if (stk_en) begin
      if (!stk_ctrl) begin
        mem[sp[1:0]] <= stk_din;
        sp <= sp + 3'd1;
      end else begin
        stk_dout <= mem[2'(sp - 3'd1)];
        sp <= sp - 3'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_cycles(input int n);
    @(posedge clk);
    #1 clr = 1;
    repeat (n) begin
      @(negedge clk);
      check("rst_clr_n", stk_clr_n, 0);
      check("rst_count", count, 0);
      check("rst_gnt_done", {gnt, done, err, stk_en, stk_ctrl}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_din", stk_din, 0);
    end
    @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    check("flush_clr_n", stk_clr_n, 0);
    @(negedge clk);
    check("idle_clr_n", stk_clr_n, 1);
    check("idle_count", count, 0);
  endtask

  task automatic do_op(input int r, input logic o, input logic [7:0] d,
                       input logic exp_err, input logic [7:0] exp_rd);
    int cyc = 0, ens = 0;
    bit seen = 0;
    @(negedge clk);
    req[r] = 1;
    op[r] = o;
    if (r == 0) wdata0 = d; else wdata1 = d;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("gnt", gnt, (r == 1) ? 2 : 1);
      if (stk_en) begin
        ens++;
        check("stk_ctrl", stk_ctrl, o);
        if (!o) check("stk_din", stk_din, d);
      end
      if (done[r]) seen = 1;
    end
    check("done_seen", seen, 1);
    check("latency", cyc, (o && !exp_err) ? 3 : 2);
    check("err", err, exp_err);
    check("stk_en_cnt", ens, exp_err ? 0 : 1);
    if (o) check("rdata", rdata, exp_rd);
    req[r] = 0;
  endtask

  initial begin
    int nf, k, t;
    reset_cycles(3);
    do_op(0, 0, 8'h11, 0, 0);
    do_op(0, 0, 8'h22, 0, 0);
    do_op(0, 0, 8'h33, 0, 0);
    do_op(0, 0, 8'h44, 0, 0);
    check("count_full", count, 4);
    do_op(0, 0, 8'h5A, 1, 0);
    check("count_overflow", count, 4);
    do_op(0, 1, 0, 0, 8'h44);
    do_op(0, 1, 0, 0, 8'h33);
    do_op(0, 1, 0, 0, 8'h22);
    do_op(0, 1, 0, 0, 8'h11);
    do_op(0, 1, 0, 1, 8'h11);
    check("count_empty", count, 0);
    do_op(1, 0, 8'h55, 0, 0);
    do_op(1, 0, 8'h66, 0, 0);
    check("count_two", count, 2);
    do_op(1, 1, 0, 0, 8'h66);
    do_op(0, 0, 8'h77, 0, 0);
    @(negedge clk);
    req[0] = 1;
    op[0] = 1;
    @(negedge clk);
    check("fl_gnt", gnt, 1);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    req[0] = 0;
    check("fl_done", done, 1);
    check("fl_err", err, 0);
    check("fl_rdata", rdata, 8'h77);
    check("fl_count_pre", count, 1);
    nf = 0;
    repeat (4) begin
      @(negedge clk);
      if (!stk_clr_n) nf++;
    end
    check("fl_cycles", nf, 1);
    check("fl_count", count, 0);
    reset_cycles(2);
    @(negedge clk);
    wdata0 = 8'hA0;
    wdata1 = 8'hB1;
    op = 0;
    req = 2'b11;
    k = 0;
    t = 0;
    while (k < 4 && t < 40) begin
      @(negedge clk);
      t++;
      if (gnt != 0) begin
        check("arb_seq", gnt, (k % 2 == 1) ? 2 : 1);
        k++;
      end
    end
    check("arb_grants", k, 4);
    @(negedge clk);
    check("arb_done", done, 2);
    req = 0;
    check("arb_count", count, 4);
    do_op(0, 1, 0, 0, 8'hB1);
    do_op(1, 1, 0, 0, 8'hA0);
    do_op(0, 1, 0, 0, 8'hB1);
    do_op(0, 1, 0, 0, 8'hA0);
    @(negedge clk);
    req[0] = 1;
    op[0] = 0;
    wdata0 = 8'h99;
    @(negedge clk);
    check("mid_gnt", gnt, 1);
    clr = 1;
    req = 0;
    #1 check("mid_clr_n", stk_clr_n, 0);
    @(posedge clk);
    #1 clr = 0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_done", done, 0);
    end
    check("mid_count", count, 0);
    do_op(0, 0, 8'hAB, 0, 0);
    check("mid_count_after", count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Sequencer and two-way arbiter for the processor's hardware stack. It accepts push and pop requests from two requesters: requester 0 is call/return control, requester 1 is interrupt entry/exit. It serializes them onto the stack's single en/ctrl/data port and tracks occupancy itself, so overflow and underflow are reported as errors and never reach the stack. It also owns the stack's clear line, both for reset and for software flush.

## Interface
- WIDTH, 8, data width in bits; must equal the stack's data width.
- DEPTH, 2, log2 of stack capacity; capacity CAP = 2**DEPTH entries.
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- req[1:0]  in  2  per-requester request; held high until that requester's done.
- op[1:0]  in  2  per-requester operation: 0 = push, 1 = pop.
- wdata0, wdata1  in  WIDTH  push data for requester 0 and 1.
- flush  in  1  one-cycle pulse: empty the stack.
- gnt[1:0]  out  2  one-hot grant, high during the ISSUE cycle.
- done[1:0]  out  2  one-cycle completion pulse to the served requester.
- err  out  1  valid with done: 1 = rejected (push when full, pop when empty).
- rdata  out  WIDTH  popped data; valid with done on a pop; holds until the next successful pop.
- count  out  DEPTH+1  current occupancy, 0..CAP.
- stk_en  out  1  stack enable.
- stk_ctrl  out  1  stack ctrl: 0 = push, 1 = pop.
- stk_din  out  WIDTH  stack data_in.
- stk_clr_n  out  1  stack synchronous active-low clear.
- stk_dout  in  WIDTH  stack data_out, registered in the stack.

## Operation
- States: FLUSH, IDLE, ISSUE, CAPT, RESP.
- Reset (clr high), all asynchronous:
  - state = FLUSH, count = 0, rdata = 0, err = 0.
  - gnt, done, stk_en and stk_ctrl are 0; stk_din = 0.
  - stk_clr_n = 0; the stack clears on every clk edge while clr is held.
  - rr_last = 1, so requester 0 wins the first tie.
- FLUSH: stk_clr_n = 0 for exactly one cycle; count <= 0; next state IDLE.
- IDLE:
  - If flush is pending, go to FLUSH. Flush has priority over requests.
  - Else if any req bit is set, the arbiter picks a requester: a single requester wins outright; on a tie, the one not equal to rr_last wins.
  - Latch the winner's index, op and wdata. Go to ISSUE.
- ISSUE:
  - gnt[winner] = 1; rr_last <= winner.
  - Legal operation (push with count < CAP, or pop with count > 0): stk_en = 1, stk_ctrl = op, stk_din = latched data. A push sets count += 1 and goes to RESP. A pop sets count -= 1 and goes to CAPT.
  - Illegal operation: stk_en stays 0, the error flag is latched, next state RESP.
- CAPT: rdata <= stk_dout; next state RESP.
- RESP: done[winner] = 1 and err = latched flag; next state IDLE.
- A requester must drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- Flush arriving in any state other than IDLE sets flush_pend. The current transaction completes normally, then FLUSH runs from IDLE. Multiple pending flushes merge into one.
- op and wdata are sampled only in IDLE; changes while granted are ignored.

## Timing
- Push: IDLE to done is 3 cycles (IDLE, ISSUE, RESP).
- Pop: 4 cycles (IDLE, ISSUE, CAPT, RESP); rdata is valid in RESP.
- Rejected operation: 3 cycles; stk_en never asserted.
- Throughput is at most one operation per 3 or 4 cycles; there is no pipelining.
- stk_en is high for at most one cycle per transaction.
- count changes only on the ISSUE-to-next edge or in FLUSH.
- Releasing clr mid-transaction: the block always restarts in FLUSH. The in-flight request is dropped without done, and the requester must re-request.

## Structure
- Package stack_arb_pkg holds:
  - state enum (FLUSH, IDLE, ISSUE, CAPT, RESP);
  - OP_PUSH = 0, OP_POP = 1, matching the stack's ctrl encoding.
- Sub-module rr_arb2: 2-requester round-robin arbiter.
  - Inputs: req[1:0], last.
  - Outputs: one-hot grant, index.
  - Purely combinational; rr_last is kept in this block.
- FSM, occupancy counter, request latch and flush_pend live in stack_arbiter.

## Test plan
- Reset then flush: hold clr 3 cycles → stk_clr_n = 0 throughout and for one cycle after release; count = 0; then IDLE.
- Push/pop order: requester 0 pushes 0x11, 0x22, 0x33, 0x44 → count = 4. A fifth push returns done with err = 1, stk_en is never asserted, and count stays 4. Four pops return 0x44, 0x33, 0x22, 0x11. A fifth pop returns err = 1.
- Arbitration: both requesters hold push requests continuously → grants alternate 0, 1, 0, 1. A tie straight after reset grants requester 0 first.
- Pop latency: pop issued with count = 2 → gnt in cycle 1, stk_en = 1 / stk_ctrl = 1 in cycle 1, rdata and done in cycle 3 relative to ISSUE as cycle 1.
- Flush deferral: flush pulse during a pop's CAPT → the pop completes with correct rdata, then one FLUSH cycle with stk_clr_n = 0, and count = 0.
- Mid-operation reset: assert clr in ISSUE → no done is issued; after release FLUSH runs and count = 0; a re-issued push succeeds with err = 0.
